// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states,
// the BTB entry view and the index-width helper.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Entry fields are sized for the widest supported XLEN; narrower builds
  // leave the upper bits at zero and synthesis trims them.
  localparam int BP_MAX_XLEN = 64;

  typedef struct packed {
    logic                   valid;
    logic [BP_MAX_XLEN-1:0] tag;
    logic [BP_MAX_XLEN-1:0] target;
    ctr_t                   ctr;
  } bp_entry_t;

  function automatic int idx_w(input int entries);
    int w;
    w = 0;
    for (int i = 0; i < 9; i++) begin
      if ((1 << i) < entries) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter; a jump
// forces the strongly-taken state.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (force_st) begin
      ctr_out = CTR_ST;
    end else if (taken) begin
      if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, combinational fetch lookup and
// execute-stage resolution. Optional statistics under BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic            pred_taken_e,
  input  logic [XLEN-1:0] pred_target_e,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e,
  input  logic            stat_clr
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_vec;
  logic [1:0]         ctr_vec    [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  bp_entry_t        lk_entry, up_entry;

  assign lk_idx = pc_f[IDX_W+1:2];
  assign lk_tag = pc_f[XLEN-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];

  always_comb begin
    lk_entry                  = '0;
    lk_entry.valid            = valid_vec[lk_idx];
    lk_entry.tag[TAG_W-1:0]   = tag_mem[lk_idx];
    lk_entry.target[XLEN-1:0] = target_mem[lk_idx];
    lk_entry.ctr              = ctr_t'(ctr_vec[lk_idx]);
  end

  always_comb begin
    up_entry                  = '0;
    up_entry.valid            = valid_vec[up_idx];
    up_entry.tag[TAG_W-1:0]   = tag_mem[up_idx];
    up_entry.target[XLEN-1:0] = target_mem[up_idx];
    up_entry.ctr              = ctr_t'(ctr_vec[up_idx]);
  end

  // Fetch-side lookup reads current state only, so a same-cycle update is
  // not visible until the following cycle.
  logic lk_hit;
  assign lk_hit        = lk_entry.valid && (lk_entry.tag[TAG_W-1:0] == lk_tag);
  assign pred_taken_f  = lk_hit && (lk_entry.ctr == CTR_WT || lk_entry.ctr == CTR_ST);
  assign pred_target_f = pred_taken_f ? lk_entry.target[XLEN-1:0] : pc_f + XLEN'(4);

  assign mispredict_e  = rst && upd_en &&
                         ((pred_taken_e != upd_taken) ||
                          (upd_taken && (pred_target_e != upd_target)));
  assign redirect_pc_e = upd_taken ? upd_target : upd_pc + XLEN'(4);

  logic       up_hit, alloc, ctr_we;
  logic [1:0] ctr_upd, ctr_next;

  assign up_hit = up_entry.valid && (up_entry.tag[TAG_W-1:0] == up_tag);
  assign alloc  = upd_en && !up_hit && upd_taken;
  assign ctr_we = (upd_en && up_hit) || alloc;

  sat_counter2 u_sat (
    .ctr_in   (up_entry.ctr),
    .taken    (upd_taken),
    .force_st (upd_is_jump),
    .ctr_out  (ctr_upd)
  );

  assign ctr_next = alloc ? (upd_is_jump ? CTR_ST : CTR_WT) : ctr_upd;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic       sel;
      logic       valid_reg;
      logic [1:0] ctr_reg;

      assign sel = (up_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_reg <= 1'b0;
          ctr_reg   <= CTR_WNT;
        end else if (sel && ctr_we) begin
          valid_reg <= 1'b1;
          ctr_reg   <= ctr_next;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign ctr_vec[gi]   = ctr_reg;
    end
  endgenerate

  // Tags and targets are meaningless while valid is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    if (alloc) tag_mem[up_idx] <= up_tag;
  end

  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) target_mem[up_idx] <= upd_target;
  end

  logic unused_bits;

`ifdef BP_STATS_EN
  logic [31:0] lookups_reg, mispredicts_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_reg     <= '0;
      mispredicts_reg <= '0;
    end else if (stat_clr) begin
      lookups_reg     <= '0;
      mispredicts_reg <= '0;
    end else begin
      if (lookup_en && (lookups_reg != '1)) lookups_reg <= lookups_reg + 32'd1;
      if (mispredict_e && (mispredicts_reg != '1)) mispredicts_reg <= mispredicts_reg + 32'd1;
    end
  end

  assign stat_lookups     = lookups_reg;
  assign stat_mispredicts = mispredicts_reg;
  assign unused_bits      = ^{lk_entry, up_entry};
`else
  assign unused_bits      = ^{lk_entry, up_entry, lookup_en, stat_clr};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (XLEN=32, ENTRIES=16): vector table plus
// reset and statistics sequences (statistics only when BP_STATS_EN is defined).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lookup_en, upd_en, upd_taken, upd_is_jump, pred_taken_e, stat_clr;
  logic [31:0] pc_f, upd_pc, upd_target, pred_target_e;
  logic        pred_taken_f, mispredict_e;
  logic [31:0] pred_target_f, redirect_pc_e;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups, stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_en     (lookup_en),
    .pc_f          (pc_f),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .upd_is_jump   (upd_is_jump),
    .pred_taken_e  (pred_taken_e),
    .pred_target_e (pred_target_e),
    .mispredict_e  (mispredict_e),
    .redirect_pc_e (redirect_pc_e),
    .stat_clr      (stat_clr)
`ifdef BP_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic        en;
    logic [31:0] upc;
    logic [31:0] utg;
    logic        tk;
    logic        j;
    logic        pte;
    logic [31:0] ptg;
    logic [31:0] pc;
    logic        e_pt;
    logic [31:0] e_tg;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic en, input logic [31:0] upc, input logic [31:0] utg,
                               input logic tk, input logic j, input logic pte,
                               input logic [31:0] ptg, input logic [31:0] pc,
                               input logic e_pt, input logic [31:0] e_tg,
                               input logic e_mis, input logic [31:0] e_red);
    vec_t v;
    v.en = en; v.upc = upc; v.utg = utg; v.tk = tk; v.j = j; v.pte = pte; v.ptg = ptg;
    v.pc = pc; v.e_pt = e_pt; v.e_tg = e_tg; v.e_mis = e_mis; v.e_red = e_red;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    lookup_en = 1'b0; upd_en = 1'b0; upd_taken = 1'b0; upd_is_jump = 1'b0;
    pred_taken_e = 1'b0; stat_clr = 1'b0;
    pc_f = 32'h100; upd_pc = '0; upd_target = '0; pred_target_e = '0;

    //        en upc          utg          tk j  pte ptg          pc           e_pt e_tg        mis red
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h100, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h100,   32'h200,   1, 0, 0, 32'h0,     32'h100, 0, 32'h104, 1, 32'h200));
    vecs.push_back(mkv(1, 32'h100,   32'h0,     0, 0, 1, 32'h200,   32'h100, 1, 32'h200, 1, 32'h104));
    vecs.push_back(mkv(1, 32'h100,   32'h0,     0, 0, 0, 32'h0,     32'h100, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h100,   32'h0,     0, 0, 0, 32'h0,     32'h100, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h100,   32'h200,   1, 0, 0, 32'h0,     32'h100, 0, 32'h104, 1, 32'h200));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h100, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h100,   32'h200,   1, 0, 0, 32'h0,     32'h100, 0, 32'h104, 1, 32'h200));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h100, 1, 32'h200, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h140,   32'h300,   1, 0, 0, 32'h0,     32'h140, 0, 32'h144, 1, 32'h300));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h140, 1, 32'h300, 0, 32'h0));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h100, 0, 32'h104, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h140,   32'h380,   1, 0, 1, 32'h300,   32'h140, 1, 32'h300, 1, 32'h380));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h140, 1, 32'h380, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h140,   32'h380,   1, 0, 1, 32'h380,   32'h140, 1, 32'h380, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h140,   32'h0,     0, 0, 1, 32'h380,   32'h140, 1, 32'h380, 1, 32'h144));
    vecs.push_back(mkv(1, 32'h140,   32'h0,     0, 0, 1, 32'h380,   32'h140, 1, 32'h380, 1, 32'h144));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h140, 0, 32'h144, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h180,   32'h400,   1, 1, 0, 32'h0,     32'h180, 0, 32'h184, 1, 32'h400));
    vecs.push_back(mkv(1, 32'h180,   32'h0,     0, 0, 1, 32'h400,   32'h180, 1, 32'h400, 1, 32'h184));
    vecs.push_back(mkv(1, 32'h180,   32'h0,     0, 0, 1, 32'h400,   32'h180, 1, 32'h400, 1, 32'h184));
    vecs.push_back(mkv(1, 32'h180,   32'h400,   1, 1, 0, 32'h0,     32'h180, 0, 32'h184, 1, 32'h400));
    vecs.push_back(mkv(1, 32'h180,   32'h0,     0, 0, 1, 32'h400,   32'h180, 1, 32'h400, 1, 32'h184));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h180, 1, 32'h400, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h1C0,   32'h0,     0, 0, 0, 32'h0,     32'h1C0, 0, 32'h1C4, 0, 32'h0));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h180, 1, 32'h400, 0, 32'h0));
    vecs.push_back(mkv(1, 32'hFFFFFFFC, 32'h0,  0, 0, 1, 32'h0,     32'hFFFFFFFC, 0, 32'h0, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h104,   32'h500,   1, 0, 0, 32'h0,     32'h104, 0, 32'h108, 1, 32'h500));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 1, 32'h0,     32'h104, 1, 32'h500, 0, 32'h0));
    vecs.push_back(mkv(0, 32'h0,     32'h0,     0, 0, 0, 32'h0,     32'h180, 1, 32'h400, 0, 32'h0));

    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      lookup_en     = 1'b1;
      upd_en        = vecs[i].en;
      upd_pc        = vecs[i].upc;
      upd_target    = vecs[i].utg;
      upd_taken     = vecs[i].tk;
      upd_is_jump   = vecs[i].j;
      pred_taken_e  = vecs[i].pte;
      pred_target_e = vecs[i].ptg;
      pc_f          = vecs[i].pc;
      #2;
      $display("vec %0d pc_f=%08h pred_taken_f=%0b pred_target_f=%08h mispredict_e=%0b redirect_pc_e=%08h",
               i, pc_f, pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e);
      check($sformatf("vec%0d pred_taken_f", i), {31'b0, pred_taken_f}, {31'b0, vecs[i].e_pt});
      check($sformatf("vec%0d pred_target_f", i), pred_target_f, vecs[i].e_tg);
      check($sformatf("vec%0d mispredict_e", i), {31'b0, mispredict_e}, {31'b0, vecs[i].e_mis});
      if (vecs[i].e_mis) check($sformatf("vec%0d redirect_pc_e", i), redirect_pc_e, vecs[i].e_red);
    end

    // Reset asserted while an allocating update is presented.
    @(negedge clk);
    lookup_en = 1'b0;
    pc_f = 32'h104; upd_en = 1'b1; upd_pc = 32'h240; upd_target = 32'h600;
    upd_taken = 1'b1; upd_is_jump = 1'b0; pred_taken_e = 1'b0; pred_target_e = '0;
    rst = 1'b0;
    #2;
    $display("reset-mid-update pred_taken_f=%0b pred_target_f=%08h mispredict_e=%0b",
             pred_taken_f, pred_target_f, mispredict_e);
    check("rst pred_taken_f", {31'b0, pred_taken_f}, 32'd0);
    check("rst pred_target_f", pred_target_f, 32'h108);
    check("rst mispredict_e", {31'b0, mispredict_e}, 32'd0);
    @(negedge clk);
    rst = 1'b1; upd_en = 1'b0; pc_f = 32'h240;
    #2;
    $display("after-reset pc_f=%08h pred_taken_f=%0b pred_target_f=%08h", pc_f, pred_taken_f, pred_target_f);
    check("discarded update pred_taken_f", {31'b0, pred_taken_f}, 32'd0);
    check("discarded update pred_target_f", pred_target_f, 32'h244);
    pc_f = 32'h104;
    #1;
    $display("after-reset pc_f=%08h pred_taken_f=%0b", pc_f, pred_taken_f);
    check("cleared entry pred_taken_f", {31'b0, pred_taken_f}, 32'd0);

`ifdef BP_STATS_EN
    // Five lookups, two of them alongside a not-taken-miss mispredict.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lookup_en = 1'b1;
      upd_en = (k == 1) || (k == 3);
      upd_pc = 32'h7C0; upd_taken = 1'b0; pred_taken_e = 1'b1; pred_target_e = 32'h0;
    end
    @(negedge clk);
    lookup_en = 1'b0; upd_en = 1'b0;
    #2;
    $display("stats lookups=%0d mispredicts=%0d", stat_lookups, stat_mispredicts);
    check("stat_lookups", stat_lookups, 32'd5);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
    @(negedge clk);
    stat_clr = 1'b1; lookup_en = 1'b1; upd_en = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0; lookup_en = 1'b0; upd_en = 1'b0;
    #2;
    $display("stats after clear lookups=%0d mispredicts=%0d", stat_lookups, stat_mispredicts);
    check("stat_lookups clr", stat_lookups, 32'd0);
    check("stat_mispredicts clr", stat_mispredicts, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
